riscv_multicycle_core: RTL and testbench
========================================

Name: riscv_multicycle_core

Overview:
Parametrised multi-cycle successor to the single-cycle R-type datapath. Adds I-type ALU ops and LUI, an optional RV32E register count, and a request/response instruction-memory handshake with stall tolerance. Illegal instructions drive a sticky trap state. Retire and debug outputs are provided for verification. It is the core top: the instruction memory sits outside and is reached only through the handshake ports.

Parameters:
NREGS, 32, architectural register count; legal values 32 (RV32I) and 16 (RV32E)
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request
imem_addr  out  32  fetch address; equals the PC
imem_ready  in  1  request accepted when imem_req and imem_ready are both high
imem_rvalid  in  1  instruction data valid
imem_rdata  in  32  instruction word
retire  out  1  one-cycle pulse per completed instruction
retire_pc  out  32  PC of the retiring instruction; valid when retire is high
trap  out  1  sticky illegal-instruction flag
instret  out  CNT_W  count of retired instructions
dbg_sel  in  5  debug register index
dbg_data  out  32  combinational read of register dbg_sel; 0 if dbg_sel >= NREGS

Behaviour:
- Reset (rst low, asynchronous) sets: state=FETCH, pc=RESET_PC, imem_req=0, retire=0, trap=0, instret=0, retire_pc=0, all registers=0.
- imem_req is a registered output. It rises on the first clock edge after reset is released.
- FETCH:
  - imem_req=1; imem_addr=pc, held stable until accepted.
  - imem_ready=1 moves to WAIT.
- WAIT:
  - imem_req=0.
  - imem_rvalid=1 latches imem_rdata into IR and moves to EXEC.
  - rvalid is sampled only in WAIT; a response arriving in any other state is ignored.
- EXEC: decode IR; read rs1/rs2; compute the result into a register.
  - Legal -> WB; illegal -> TRAP.
- WB:
  - Write rd only if rd != 0.
  - pc <= pc+4; retire=1 for this cycle; retire_pc=pc; instret <= instret+1.
  - Next state: FETCH.
- TRAP: trap=1, imem_req=0, no register writes, no retire. Left only by reset.
- Latency: 4 cycles per instruction when imem_ready is high in FETCH and rvalid arrives the first WAIT cycle. Each stall cycle adds 1.
- Legal instructions:
  - OP (0110011), funct7 0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - OP, funct7 0100000: SUB, SRA only.
  - OP-IMM (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI. SLLI and SRLI require imm[11:5]=0000000; SRAI requires imm[11:5]=0100000.
  - LUI (0110111).
- Everything else is illegal, including any rs1/rs2/rd index >= NREGS. For LUI only rd is checked; for OP-IMM rs2 is not checked.
- Arithmetic:
  - Results wrap modulo 2^32; immediates are sign-extended to 32 bits.
  - Shift amount is rs2[4:0] or imm[4:0].
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned; results are 0 or 1.
  - LUI writes {imm[31:12], 12'h0}.
- Wrap-around: pc wraps at 2^32; instret wraps from all-ones to 0.
- x0 always reads 0. A write to rd=0 is discarded but still retires.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants (OP, OP_IMM, LUI)
  - funct3 and funct7 constants
  - ALU operation enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB)
  - FSM state enum (FETCH, WAIT, EXEC, WB, TRAP)
- Sub-module riscv_regfile, parametrised by NREGS:
  - two combinational read ports plus a debug read port
  - one synchronous write port gated by write enable and rd != 0
  - asynchronous active-low clear to 0
- ALU, decoder and FSM stay in the top.

Test Plan:
- Reset -> imem_req=0 while rst is low; imem_req=1 and imem_addr=0x00000000 after the first edge; trap=0; instret=0.
- ADDI x1,x0,5 (0x00500093) then ADD x2,x1,x1 (0x00108133), zero-wait memory -> dbg x1=5, x2=10; retire pulses 4 cycles apart with retire_pc 0x0 then 0x4; instret=2.
- SUB x3,x0,x1 (0x401001B3) with x1=5 -> x3=0xFFFFFFFB; then SRAI x4,x3,1 (0x4011D213) -> x4=0xFFFFFFFD.
- ADDI x0,x0,7 (0x00700013) -> dbg x0=0; retire pulses; instret increments.
- Stall: imem_ready low for 3 cycles, then rvalid 5 cycles after acceptance -> imem_addr stable throughout; no retire until data arrives; exactly one retire.
- Illegal 0x00000000 -> trap=1 two cycles after rvalid; no retire; imem_req stays 0 for 20 cycles; instret unchanged. With NREGS=16, ADDI x16,x0,1 (0x00100813) also traps. Reset clears trap.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I/E core: opcode and funct fields, ALU operations, FSM states.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_FETCH, ST_WAIT, ST_EXEC, ST_WB, ST_TRAP
    } state_t;

endpackage

// File: rtl/riscv_regfile.sv
// Architectural register file: two combinational read ports plus a debug port, one synchronous write.
// Indices at or above NREGS read as 0 and are never written; x0 is hard-wired to 0.
module riscv_regfile #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic [4:0]  dbg_sel,
    output logic [31:0] dbg_data,
    input  logic        we,
    input  logic [4:0]  rd,
    input  logic [31:0] rd_data
);

    localparam int         AW    = $clog2(NREGS);
    localparam logic [5:0] LIMIT = 6'(NREGS);

    logic [31:0] regs [NREGS];

    assign rs1_data = ({1'b0, rs1} < LIMIT) ? regs[rs1[AW-1:0]] : 32'h0;
    assign rs2_data = ({1'b0, rs2} < LIMIT) ? regs[rs2[AW-1:0]] : 32'h0;
    assign dbg_data = ({1'b0, dbg_sel} < LIMIT) ? regs[dbg_sel[AW-1:0]] : 32'h0;

    // regs[0] is cleared on reset and excluded from writes, so x0 reads as 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (we && rd != 5'd0 && {1'b0, rd} < LIMIT) begin
            regs[rd[AW-1:0]] <= rd_data;
        end
    end

endmodule

// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I/E core (R-type, I-type ALU, LUI): FETCH/WAIT/EXEC/WB, 4 cycles per instruction.
// Each imem_ready-low cycle in FETCH or rvalid-low cycle in WAIT adds one cycle; illegal opcodes park in TRAP.
module riscv_multicycle_core
    import riscv_pkg::*;
#(
    parameter int          NREGS    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             retire,
    output logic [31:0]      retire_pc,
    output logic             trap,
    output logic [CNT_W-1:0] instret,
    input  logic [4:0]       dbg_sel,
    output logic [31:0]      dbg_data
);

    localparam logic [5:0] LIMIT = 6'(NREGS);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] result;

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] op_b;
    logic [31:0] alu_y;
    logic [4:0]  shamt;
    alu_op_t     alu_op;
    logic        use_imm;
    logic        legal;

    function automatic logic in_range(input logic [4:0] idx);
        return {1'b0, idx} < LIMIT;
    endfunction

    assign opcode    = ir[6:0];
    assign rd        = ir[11:7];
    assign funct3    = ir[14:12];
    assign rs1       = ir[19:15];
    assign rs2       = ir[24:20];
    assign funct7    = ir[31:25];
    assign imm_i     = {{20{ir[31]}}, ir[31:20]};
    assign imm_u     = {ir[31:12], 12'h000};
    assign imem_addr = pc;

    riscv_regfile #(
        .NREGS(NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
        .we       (state == ST_WB),
        .rd       (rd),
        .rd_data  (result)
    );

    // For OP-IMM the funct7 bits are imm[11:5], which qualify the shift encodings.
    always_comb begin
        alu_op  = ALU_ADD;
        use_imm = 1'b0;
        imm     = imm_i;
        legal   = 1'b0;
        case (opcode)
            OPC_OP: begin
                legal = in_range(rd) && in_range(rs1) && in_range(rs2);
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD:  alu_op = ALU_ADD;
                        F3_SLL:  alu_op = ALU_SLL;
                        F3_SLT:  alu_op = ALU_SLT;
                        F3_SLTU: alu_op = ALU_SLTU;
                        F3_XOR:  alu_op = ALU_XOR;
                        F3_SR:   alu_op = ALU_SRL;
                        F3_OR:   alu_op = ALU_OR;
                        default: alu_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    alu_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
                    alu_op = ALU_SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                legal   = in_range(rd) && in_range(rs1);
                use_imm = 1'b1;
                case (funct3)
                    F3_ADD:  alu_op = ALU_ADD;
                    F3_SLT:  alu_op = ALU_SLT;
                    F3_SLTU: alu_op = ALU_SLTU;
                    F3_XOR:  alu_op = ALU_XOR;
                    F3_OR:   alu_op = ALU_OR;
                    F3_AND:  alu_op = ALU_AND;
                    F3_SLL: begin
                        alu_op = ALU_SLL;
                        if (funct7 != F7_BASE) legal = 1'b0;
                    end
                    default: begin
                        if (funct7 == F7_BASE)     alu_op = ALU_SRL;
                        else if (funct7 == F7_ALT) alu_op = ALU_SRA;
                        else                       legal  = 1'b0;
                    end
                endcase
            end
            OPC_LUI: begin
                legal   = in_range(rd);
                use_imm = 1'b1;
                imm     = imm_u;
                alu_op  = ALU_PASSB;
            end
            default: legal = 1'b0;
        endcase
    end

    assign op_b  = use_imm ? imm : rs2_data;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_y = 32'h0;
        case (alu_op)
            ALU_ADD:  alu_y = rs1_data + op_b;
            ALU_SUB:  alu_y = rs1_data - op_b;
            ALU_SLL:  alu_y = rs1_data << shamt;
            ALU_SLT:  alu_y = {31'h0, $signed(rs1_data) < $signed(op_b)};
            ALU_SLTU: alu_y = {31'h0, rs1_data < op_b};
            ALU_XOR:  alu_y = rs1_data ^ op_b;
            ALU_SRL:  alu_y = rs1_data >> shamt;
            ALU_SRA:  alu_y = $unsigned($signed(rs1_data) >>> shamt);
            ALU_OR:   alu_y = rs1_data | op_b;
            ALU_AND:  alu_y = rs1_data & op_b;
            default:  alu_y = op_b;
        endcase
    end

    // imem_req is raised on entry to FETCH (from WB) so back-to-back instructions take 4 cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            ir        <= 32'h0;
            result    <= 32'h0;
            imem_req  <= 1'b0;
            retire    <= 1'b0;
            retire_pc <= 32'h0;
            trap      <= 1'b0;
            instret   <= '0;
        end else begin
            retire <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (imem_req && imem_ready) begin
                        imem_req <= 1'b0;
                        state    <= ST_WAIT;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        ir    <= imem_rdata;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (legal) begin
                        result    <= alu_y;
                        retire    <= 1'b1;
                        retire_pc <= pc;
                        state     <= ST_WB;
                    end else begin
                        trap  <= 1'b1;
                        state <= ST_TRAP;
                    end
                end
                ST_WB: begin
                    pc       <= pc + 32'd4;
                    instret  <= instret + CNT_W'(1);
                    imem_req <= 1'b1;
                    state    <= ST_FETCH;
                end
                default: begin
                    imem_req <= 1'b0;
                    trap     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Scoreboarded bench for riscv_multicycle_core: directed program with a stall, an illegal-op trap and an RV32E instance.
module tb_riscv_multicycle_core;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] val;
        int          gap;
    } exp_t;

    localparam logic [31:0] STALL_PC = 32'h0000_0028;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ready, imem_rvalid, retire, trap;
    logic [31:0] imem_addr, imem_rdata, retire_pc, instret, dbg_data;
    logic [4:0]  dbg_sel, mon_sel, stim_sel;
    logic        stim_mode;

    logic        req16, ready16, rvalid16, retire16, trap16;
    logic [31:0] addr16, rdata16, rpc16, instret16, data16;
    logic [4:0]  sel16;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rvalid_cyc = 0;
    int          rd_cnt = 0;
    int          rv_cnt = 0;
    int          rdy_d = 0;
    int          rv_d = 0;
    int          nret = 0;
    int          last_cyc = 0;
    int          ret16_cnt = 0;
    int          n = 0;
    int          quiet_bad = 0;
    logic        pending = 1'b0;
    logic        pend16 = 1'b0;
    logic        pend_chk = 1'b0;
    logic [31:0] acc_addr = 32'h0;
    logic [31:0] acc16 = 32'h0;
    logic [31:0] exp_fetch = 32'h0;
    logic [31:0] pend_val = 32'h0;
    logic [31:0] mem [256];
    logic [31:0] prog16 [2];
    logic [31:0] exp_regs [11];
    exp_t        sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign dbg_sel = stim_mode ? stim_sel : mon_sel;

    riscv_multicycle_core dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .retire(retire), .retire_pc(retire_pc), .trap(trap), .instret(instret),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    riscv_multicycle_core #(.NREGS(16)) dut16 (
        .clk(clk), .rst(rst),
        .imem_req(req16), .imem_addr(addr16), .imem_ready(ready16),
        .imem_rvalid(rvalid16), .imem_rdata(rdata16),
        .retire(retire16), .retire_pc(rpc16), .trap(trap16), .instret(instret16),
        .dbg_sel(sel16), .dbg_data(data16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] w, input logic [4:0] rd,
                        input logic [31:0] v, input int gap);
        exp_t e;
        mem[a[9:2]] = w;
        e.pc  = a;
        e.rd  = rd;
        e.val = v;
        e.gap = gap;
        sb.push_back(e);
    endtask

    // Main memory: zero-wait except for STALL_PC (3 ready-low cycles, 4 extra WAIT cycles).
    initial begin
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (pending) begin
                rv_d = (acc_addr == STALL_PC) ? 4 : 0;
                if (rv_cnt == rv_d) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem[acc_addr[9:2]];
                    pending     = 1'b0;
                    rvalid_cyc  = cyc;
                end else begin
                    rv_cnt++;
                end
            end
            imem_ready = 1'b0;
            if (imem_req && !pending) begin
                rdy_d = (imem_addr == STALL_PC) ? 3 : 0;
                if (rd_cnt >= rdy_d) begin
                    imem_ready = 1'b1;
                    pending    = 1'b1;
                    rv_cnt     = 0;
                    rd_cnt     = 0;
                    acc_addr   = imem_addr;
                end else begin
                    rd_cnt++;
                end
            end
        end
    end

    // RV32E instance memory: zero-wait.
    initial begin
        ready16  = 1'b0;
        rvalid16 = 1'b0;
        rdata16  = 32'h0;
        forever begin
            @(negedge clk);
            if (retire16) ret16_cnt++;
            rvalid16 = 1'b0;
            if (pend16) begin
                rvalid16 = 1'b1;
                rdata16  = prog16[acc16[2]];
                pend16   = 1'b0;
            end
            ready16 = 1'b0;
            if (req16) begin
                ready16 = 1'b1;
                pend16  = 1'b1;
                acc16   = addr16;
            end
        end
    end

    // Monitor: compares each retire against the scoreboard, then the written register one cycle later.
    initial begin
        exp_t e;
        mon_sel = 5'd0;
        forever begin
            @(negedge clk);
            if (pend_chk) begin
                chk("reg_writeback", dbg_data, pend_val);
                pend_chk = 1'b0;
            end
            if (imem_req) chk("imem_addr", imem_addr, exp_fetch);
            if (retire) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_retire: got pc %h expected no retire", retire_pc);
                end else begin
                    e = sb.pop_front();
                    chk("retire_pc", retire_pc, e.pc);
                    chk("instret_at_retire", instret, nret);
                    if (e.gap > 0) chk("retire_gap", cyc - last_cyc, e.gap);
                    exp_fetch = e.pc + 32'd4;
                    mon_sel   = e.rd;
                    pend_val  = e.val;
                    pend_chk  = 1'b1;
                end
                nret++;
                last_cyc = cyc;
            end
        end
    end

    initial begin
        rst       = 1'b0;
        stim_mode = 1'b0;
        stim_sel  = 5'd0;
        sel16     = 5'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        prog16[0] = 32'h00100793;
        prog16[1] = 32'h00100813;
        exp_regs = '{32'h0, 32'h5, 32'hA, 32'hFFFFFFFB, 32'hFFFFFFFD, 32'h12345000,
                     32'h1, 32'h0, 32'hF, 32'hFFFFFFFA, 32'hFFFFFFFF};

        load(32'h00, 32'h00500093, 5'd1,  32'h00000005, 0);
        load(32'h04, 32'h00108133, 5'd2,  32'h0000000A, 4);
        load(32'h08, 32'h401001B3, 5'd3,  32'hFFFFFFFB, 4);
        load(32'h0C, 32'h4011D213, 5'd4,  32'hFFFFFFFD, 4);
        load(32'h10, 32'h00700013, 5'd0,  32'h00000000, 4);
        load(32'h14, 32'h123452B7, 5'd5,  32'h12345000, 4);
        load(32'h18, 32'h0011A333, 5'd6,  32'h00000001, 4);
        load(32'h1C, 32'h0011B3B3, 5'd7,  32'h00000000, 4);
        load(32'h20, 32'h01C1D413, 5'd8,  32'h0000000F, 4);
        load(32'h24, 32'hFFF0C493, 5'd9,  32'hFFFFFFFA, 4);
        load(32'h28, 32'hFFA08513, 5'd10, 32'hFFFFFFFF, 11);

        repeat (3) @(negedge clk);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_trap", trap, 0);
        chk("rst_instret", instret, 0);
        chk("rst_retire", retire, 0);
        chk("rst_retire_pc", retire_pc, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);

        n = 0;
        while (!trap && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!trap) begin
            total++;
            bad++;
            $display("FAIL trap_timeout: got trap=0 expected trap=1 within 400 cycles");
        end else begin
            chk("trap_delay", cyc - rvalid_cyc, 2);
        end
        chk("all_retired", sb.size(), 0);
        chk("instret_at_trap", instret, 11);

        quiet_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (imem_req || retire || !trap) quiet_bad++;
        end
        chk("quiet_after_trap", quiet_bad, 0);
        chk("instret_after_trap", instret, 11);

        stim_mode = 1'b1;
        for (int i = 0; i < 11; i++) begin
            stim_sel = 5'(i);
            #1;
            chk($sformatf("final_x%0d", i), dbg_data, exp_regs[i]);
        end

        sel16 = 5'd15;
        #1;
        chk("e_x15", data16, 32'h1);
        sel16 = 5'd16;
        #1;
        chk("e_dbg_out_of_range", data16, 32'h0);
        chk("e_trap", trap16, 1);
        chk("e_instret", instret16, 1);
        chk("e_retires", ret16_cnt, 1);

        @(negedge clk);
        rst = 1'b0;
        stim_sel = 5'd1;
        #1;
        chk("rst2_trap", trap, 0);
        chk("rst2_instret", instret, 0);
        chk("rst2_imem_req", imem_req, 0);
        chk("rst2_e_trap", trap16, 0);
        chk("rst2_x1", dbg_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
